mux_nto1_stream: RTL and testbench

Parametrised N-input, WIDTH-bit registered stream multiplexer. It generalises the 32-bit 2:1 datapath mux to NUM_IN channels and adds valid/ready handshaking, a one-cycle output register, and a selectable round-robin arbitration mode. It sits between datapath producers (ALU result, memory read data, forwarding paths) and a single consumer that may stall.

---
 rtl/mux_nto1_stream.sv | 114 +++++++++++
 tb/tb_mux_nto1_stream.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N-input registered stream multiplexer with valid/ready
// handshaking. MODE=0 routes the channel picked by sel. MODE=1 arbitrates
// round-robin among the valid channels, starting from the channel after the
// last winner.
module mux_nto1_stream #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int MODE   = 0,
  localparam int SELW  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SELW-1:0]         sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SELW-1:0]         out_ch
);

  // One extra bit so that NUM_IN itself and pointer+offset sums are representable.
  localparam logic [SELW:0]   NUM_IN_W = (SELW+1)'(NUM_IN);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(NUM_IN - 1);

  logic [WIDTH-1:0]  ch_data [NUM_IN];
  logic [NUM_IN-1:0] grant;
  logic [SELW-1:0]   grant_idx;
  logic              grant_any;
  logic [SELW:0]     scan_sum;
  logic [SELW-1:0]   scan_idx;
  logic              load_en;
  logic              xfer;

  logic [WIDTH-1:0]  out_data_reg;
  logic              out_valid_reg;
  logic [SELW-1:0]   out_ch_reg;
  logic [SELW-1:0]   rr_ptr_reg;
  logic [SELW-1:0]   rr_ptr_next;

  // The slot can take a new word when it is empty or being drained this cycle.
  assign load_en = !out_valid_reg | out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = grant[gi] & load_en;
    end
  endgenerate

  // Grant selection: external select, or a wrapping scan upward from rr_ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (MODE == 0) begin
      // An out-of-range select grants nothing, so no channel is ever ready.
      if ({1'b0, sel} < NUM_IN_W) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        grant_any  = 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        scan_sum = {1'b0, rr_ptr_reg} + (SELW+1)'(k);
        if (scan_sum >= NUM_IN_W) begin
          scan_sum = scan_sum - NUM_IN_W;
        end
        scan_idx = scan_sum[SELW-1:0];
        if (!grant_any && in_valid[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          grant_idx       = scan_idx;
          grant_any       = 1'b1;
        end
      end
    end
  end

  // A transfer needs a granted channel that is valid while the slot can load.
  assign xfer = grant_any & in_valid[grant_idx] & load_en;

  // Next round-robin start: the channel just after the winner, wrapping.
  assign rr_ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;

  // Output slot and round-robin pointer; reset empties the slot immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      if (xfer) begin
        out_data_reg  <= ch_data[grant_idx];
        out_ch_reg    <= grant_idx;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (MODE != 0 && xfer) begin
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb_mux_nto1_stream: three instances (MODE=0/N=4, MODE=1/N=4, MODE=0/N=3)
// checked every cycle against a behavioural model, plus directed literal
// expectations for the select, stall, round-robin and reset scenarios.
module tb_mux_nto1_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, indexed by instance u = 0 (sel, N=4), 1 (rr, N=4), 2 (sel, N=3)
  logic [31:0] st_data  [3][4];
  logic [3:0]  st_valid [3];
  logic [1:0]  st_sel   [3];
  logic        st_ordy  [3];

  logic [31:0] o_data  [3];
  logic        o_valid [3];
  logic [1:0]  o_ch    [3];
  logic [3:0]  o_ready [3];

  logic [127:0] d0_in, d1_in;
  logic [95:0]  d2_in;
  logic [3:0]   r0, r1;
  logic [2:0]   r2;

  assign d0_in = {st_data[0][3], st_data[0][2], st_data[0][1], st_data[0][0]};
  assign d1_in = {st_data[1][3], st_data[1][2], st_data[1][1], st_data[1][0]};
  assign d2_in = {st_data[2][2], st_data[2][1], st_data[2][0]};
  assign o_ready[0] = r0;
  assign o_ready[1] = r1;
  assign o_ready[2] = {1'b0, r2};

  mux_nto1_stream #(.WIDTH(32), .NUM_IN(4), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(d0_in), .in_valid(st_valid[0]),
    .in_ready(r0), .sel(st_sel[0]), .out_data(o_data[0]),
    .out_valid(o_valid[0]), .out_ready(st_ordy[0]), .out_ch(o_ch[0]));

  mux_nto1_stream #(.WIDTH(32), .NUM_IN(4), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1_in), .in_valid(st_valid[1]),
    .in_ready(r1), .sel(st_sel[1]), .out_data(o_data[1]),
    .out_valid(o_valid[1]), .out_ready(st_ordy[1]), .out_ch(o_ch[1]));

  mux_nto1_stream #(.WIDTH(32), .NUM_IN(3), .MODE(0)) dut2 (
    .clk(clk), .rst(rst), .in_data(d2_in), .in_valid(st_valid[2][2:0]),
    .in_ready(r2), .sel(st_sel[2]), .out_data(o_data[2]),
    .out_valid(o_valid[2]), .out_ready(st_ordy[2]), .out_ch(o_ch[2]));

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [3];
  logic [31:0] m_data  [3];
  int          m_ch    [3];
  int          m_ptr   [3];

  function automatic int n_of(input int u);
    return (u == 2) ? 3 : 4;
  endfunction

  function automatic bit rr_of(input int u);
    return (u == 1);
  endfunction

  function automatic bit slot_free(input int u);
    return !m_valid[u] || st_ordy[u];
  endfunction

  // Channel offered the slot this cycle, or -1.
  function automatic int grant_of(input int u);
    if (!rr_of(u))
      return (int'(st_sel[u]) < n_of(u)) ? int'(st_sel[u]) : -1;
    for (int k = 0; k < n_of(u); k++) begin
      int c;
      c = (m_ptr[u] + k) % n_of(u);
      if (st_valid[u][c]) return c;
    end
    return -1;
  endfunction

  // Channel that actually transfers this cycle, or -1.
  function automatic int xfer_of(input int u);
    int g;
    g = grant_of(u);
    if (g >= 0 && st_valid[u][g] && slot_free(u)) return g;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int u);
    logic [3:0] r;
    int g;
    r = '0;
    g = grant_of(u);
    if (g >= 0 && slot_free(u)) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 3; u++) begin
        m_valid[u] <= 1'b0;
        m_data[u]  <= '0;
        m_ch[u]    <= 0;
        m_ptr[u]   <= 0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (xfer_of(u) >= 0) begin
          m_valid[u] <= 1'b1;
          m_data[u]  <= st_data[u][xfer_of(u)];
          m_ch[u]    <= xfer_of(u);
          if (rr_of(u)) m_ptr[u] <= (xfer_of(u) + 1) % n_of(u);
        end else if (st_ordy[u]) begin
          m_valid[u] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int u = 0; u < 3; u++) begin
        check($sformatf("model u%0d out_valid", u), 32'(o_valid[u]), 32'(m_valid[u]));
        check($sformatf("model u%0d out_data", u), o_data[u], m_data[u]);
        check($sformatf("model u%0d out_ch", u), 32'(o_ch[u]), 32'(m_ch[u]));
        check($sformatf("model u%0d in_ready", u), 32'(o_ready[u]), 32'(exp_ready(u)));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int u, input bit v,
                            input int ch, input logic [31:0] data);
    $display("txn %s: dut%0d valid=%0d ch=%0d data=%08h", name, u, o_valid[u], o_ch[u], o_data[u]);
    check({name, " valid"}, 32'(o_valid[u]), 32'(v));
    if (v) begin
      check({name, " ch"}, 32'(o_ch[u]), 32'(ch));
      check({name, " data"}, o_data[u], data);
    end
  endtask

  logic [31:0] basic_exp [4];
  logic [1:0]  skip_exp  [2];

  initial begin
    for (int u = 0; u < 3; u++) begin
      for (int c = 0; c < 4; c++) st_data[u][c] = '0;
      st_valid[u] = '0;
      st_sel[u]   = '0;
      st_ordy[u]  = 1'b0;
    end
    basic_exp[0] = 32'h0000_0001;
    basic_exp[1] = 32'h0000_0002;
    basic_exp[2] = 32'hF000_0001;
    basic_exp[3] = 32'hF000_0002;
    skip_exp[0]  = 2'd1;
    skip_exp[1]  = 2'd3;

    #1 rst = 1'b1;
    #1;
    check("reset out_valid", 32'(o_valid[0]), 32'h0);
    check("reset out_data", o_data[0], 32'h0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Basic select on dut0; dut2 keeps its slot full from ch0.
    for (int c = 0; c < 4; c++) st_data[0][c] = basic_exp[c];
    st_valid[0] = 4'hF;
    st_ordy[0]  = 1'b1;
    for (int c = 0; c < 3; c++) st_data[2][c] = 32'hA0 + 32'(c);
    st_valid[2] = 4'h7;
    st_ordy[2]  = 1'b1;
    st_ordy[1]  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_sel[0] = 2'(i);
      tick();
      expect_out($sformatf("basic sel%0d", i), 0, 1'b1, i, basic_exp[i]);
    end

    // Out-of-range select on the 3-input instance.
    expect_out("oor before", 2, 1'b1, 0, 32'hA0);
    st_sel[2] = 2'd3;
    #1;
    check("oor in_ready", 32'(o_ready[2]), 32'h0);
    tick();
    expect_out("oor after", 2, 1'b0, 0, 32'h0);

    // Backpressure on dut0.
    st_sel[0]     = 2'd1;
    st_data[0][1] = 32'hDEAD_BEEF;
    tick();
    expect_out("bp load", 0, 1'b1, 1, 32'hDEAD_BEEF);
    st_ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("bp stall%0d", i), 0, 1'b1, 1, 32'hDEAD_BEEF);
      check("bp in_ready", 32'(o_ready[0]), 32'h0);
      st_data[0][1] = 32'h1234_5678;
    end
    st_ordy[0] = 1'b1;
    #1;
    check("bp release in_ready", 32'(o_ready[0]), 32'h2);
    expect_out("bp drain", 0, 1'b1, 1, 32'hDEAD_BEEF);
    tick();
    expect_out("bp next", 0, 1'b1, 1, 32'h1234_5678);

    // Round-robin fairness on dut1.
    for (int c = 0; c < 4; c++) st_data[1][c] = 32'h100 + 32'(c);
    st_valid[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out($sformatf("rr fair%0d", i), 1, 1'b1, i % 4, 32'h100 + 32'(i % 4));
    end

    // Skip invalid channels, then wrap from pointer 3 to channel 0.
    st_valid[1] = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("rr skip%0d", i), 1, 1'b1, int'(skip_exp[i % 2]),
                 32'h100 + 32'(skip_exp[i % 2]));
    end
    st_valid[1] = 4'b0100;
    tick();
    expect_out("rr to3", 1, 1'b1, 2, 32'h102);
    st_valid[1] = 4'b0001;
    tick();
    expect_out("rr wrap", 1, 1'b1, 0, 32'h100);
    st_valid[1] = 4'b0000;

    // Reset while dut0 is stalled with a full slot.
    st_ordy[0] = 1'b0;
    tick();
    expect_out("rst hold", 0, 1'b1, 1, 32'h1234_5678);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst mid out_valid", 32'(o_valid[0]), 32'h0);
    check("rst mid out_data", o_data[0], 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    st_valid[1] = 4'b1001;
    tick();
    expect_out("rst first grant", 1, 1'b1, 0, 32'h100);

    // Randomised traffic on all instances, checked by the model each cycle.
    for (int i = 0; i < 1500; i++) begin
      for (int u = 0; u < 3; u++) begin
        for (int c = 0; c < 4; c++) st_data[u][c] = $urandom;
        st_valid[u] = 4'($urandom);
        st_sel[u]   = 2'($urandom);
        st_ordy[u]  = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
